// File: rtl/ldpc_dvb_dec_cnode_restore_sched_pkg.sv
// Shared LDPC DVB decoder types used by the check-node restore scheduler.
// Column index, degree and min-word widths live here so the decoder stages agree.
package ldpc_dvb_dec_cnode_restore_sched_pkg;

  localparam int cCOL_W = 3;
  localparam int cMIN_W = 16;

  typedef logic [cCOL_W-1:0] vn_min_col_t;
  typedef logic [cCOL_W:0]   vn_deg_t;
  typedef logic [cMIN_W-1:0] vn_min_t;

endpackage

// File: rtl/ldpc_dvb_dec_cnode_restore_sched.sv
// Check-node restore scheduler: fetches one min word per row and replays it
// over pDEG_MAX vnode slots, masking slots beyond the row's active degree.
module ldpc_dvb_dec_cnode_restore_sched
  import ldpc_dvb_dec_cnode_restore_sched_pkg::*;
#(
  parameter int pDEG_MAX = 8,
  parameter int pROW_W   = 10
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic                istart,
  input  logic [pROW_W-1:0]   irow_num,
  input  vn_deg_t             irow_deg,
  output logic                omin_rden,
  output logic [pROW_W-1:0]   omin_raddr,
  input  vn_min_t             imin_rdat,
  input  logic [pDEG_MAX-1:0] isign_rdat,
  output logic                oval,
  output vn_min_col_t         ovnode_idx,
  output logic                ovnode_sign,
  output logic                ovnode_mask,
  output vn_min_t             ovn_min,
  output logic [pROW_W-1:0]   octx,
  output logic                obusy,
  output logic                odone
);

  localparam int cRD_LAT = 2;
  localparam vn_min_col_t cSLOT_LAST = vn_min_col_t'(pDEG_MAX - 1);
  localparam vn_deg_t cDEG_MAX = vn_deg_t'(pDEG_MAX);
  localparam logic [pROW_W-1:0] cROW_ONE = {{(pROW_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    LOAD  = 3'd3,
    ISSUE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [pROW_W-1:0]   row_cnt_r, row_nxt_s;
  vn_min_col_t         slot_cnt_r, slot_nxt_s;
  logic [pROW_W-1:0]   row_num_r;
  vn_deg_t             row_deg_r;
  logic                latch_s;
  logic [cRD_LAT-1:0]  rd_pipe_r;
  vn_min_t             min_hold_r;
  logic [pDEG_MAX-1:0] sign_hold_r;
  vn_min_t             min_sel_s;
  logic [pDEG_MAX-1:0] sign_sel_s;
  vn_deg_t             deg_lim_s;

  // next-state, row and slot counter logic
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_cnt_r;
    slot_nxt_s  = slot_cnt_r;
    latch_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (istart) begin
          latch_s     = 1'b1;
          row_nxt_s   = '0;
          slot_nxt_s  = '0;
          state_nxt_s = (irow_num == '0) ? DONE : FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: state_nxt_s = WAIT;
      WAIT:  state_nxt_s = LOAD;
      LOAD: begin
        slot_nxt_s  = '0;
        state_nxt_s = ISSUE;
      end
      ISSUE: begin
        if (slot_cnt_r == cSLOT_LAST) begin
          slot_nxt_s = '0;
          if (row_cnt_r == row_num_r - cROW_ONE) begin
            state_nxt_s = DONE;
          end else begin
            row_nxt_s   = row_cnt_r + cROW_ONE;
            state_nxt_s = FETCH;
          end
        end else begin
          slot_nxt_s  = slot_cnt_r + vn_min_col_t'(1);
          state_nxt_s = ISSUE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // slot 0 of a row is issued straight from the read port, later slots from the hold regs
  always_comb begin
    if (state_r == LOAD) begin
      min_sel_s  = imin_rdat;
      sign_sel_s = isign_rdat;
    end else begin
      min_sel_s  = min_hold_r;
      sign_sel_s = sign_hold_r;
    end
    deg_lim_s = (row_deg_r > cDEG_MAX) ? cDEG_MAX : row_deg_r;
  end

  // control state and control outputs
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_r    <= IDLE;
      row_cnt_r  <= '0;
      slot_cnt_r <= '0;
      row_num_r  <= '0;
      row_deg_r  <= '0;
      rd_pipe_r  <= '0;
      omin_rden  <= 1'b0;
      omin_raddr <= '0;
      oval       <= 1'b0;
      obusy      <= 1'b0;
      odone      <= 1'b0;
    end else if (iclkena) begin
      state_r    <= state_nxt_s;
      row_cnt_r  <= row_nxt_s;
      slot_cnt_r <= slot_nxt_s;
      if (latch_s) begin
        row_num_r <= irow_num;
        row_deg_r <= irow_deg;
      end
      rd_pipe_r  <= {rd_pipe_r[cRD_LAT-2:0], omin_rden};
      omin_rden  <= (state_nxt_s == FETCH);
      if (state_nxt_s == FETCH) begin
        omin_raddr <= row_nxt_s;
      end
      oval  <= (state_nxt_s == ISSUE);
      obusy <= (state_nxt_s != IDLE);
      odone <= (state_nxt_s == DONE);
    end
  end

  // datapath holding and per-slot output registers
  always_ff @(posedge iclk) begin
    if (iclkena) begin
      if (rd_pipe_r[cRD_LAT-1]) begin
        min_hold_r  <= imin_rdat;
        sign_hold_r <= isign_rdat;
      end
      if (state_nxt_s == ISSUE) begin
        ovnode_idx  <= slot_nxt_s;
        ovnode_sign <= sign_sel_s[slot_nxt_s];
        ovnode_mask <= ({1'b0, slot_nxt_s} >= deg_lim_s);
        ovn_min     <= min_sel_s;
        octx        <= row_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_dvb_dec_cnode_restore_sched.sv
// Randomized directed bench for the check-node restore scheduler with a
// row/slot reference model and a 2-cycle min-memory model.
module tb_ldpc_dvb_dec_cnode_restore_sched;
  import ldpc_dvb_dec_cnode_restore_sched_pkg::*;

  localparam int NDEG = 8;

  logic iclk = 1'b0;
  logic ireset, iclkena, istart;
  logic [9:0] irow_num;
  vn_deg_t irow_deg;
  logic omin_rden, oval, ovnode_sign, ovnode_mask, obusy, odone;
  logic [9:0] omin_raddr, octx;
  vn_min_t imin_rdat, ovn_min;
  logic [NDEG-1:0] isign_rdat;
  vn_min_col_t ovnode_idx;

  ldpc_dvb_dec_cnode_restore_sched #(.pDEG_MAX(NDEG), .pROW_W(10)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart),
    .irow_num(irow_num), .irow_deg(irow_deg),
    .omin_rden(omin_rden), .omin_raddr(omin_raddr),
    .imin_rdat(imin_rdat), .isign_rdat(isign_rdat),
    .oval(oval), .ovnode_idx(ovnode_idx), .ovnode_sign(ovnode_sign),
    .ovnode_mask(ovnode_mask), .ovn_min(ovn_min), .octx(octx),
    .obusy(obusy), .odone(odone)
  );

  always #5 iclk = ~iclk;

  // min memory: address registered on each enabled edge, data out two enabled edges later
  vn_min_t mem_min [16];
  logic [NDEG-1:0] mem_sign [16];
  logic [9:0] a1 = 10'd0, a2 = 10'd0;
  always @(posedge iclk) if (iclkena) begin a1 <= omin_raddr; a2 <= a1; end
  assign imin_rdat  = mem_min[a2[3:0]];
  assign isign_rdat = mem_sign[a2[3:0]];

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int start_cyc = 0;
  logic [31:0] obs_q[$];
  int rd_rel_q[$], rd_addr_q[$], val_rel_q[$];
  int done_cnt = 0, done_rel = -1;
  int total = 0, bad = 0;

  // monitor: each displayed value counted once, on the enabled edge that consumes it
  always @(negedge iclk) begin
    if (iclkena) begin
      if (oval) begin
        obs_q.push_back({1'b0, octx, ovn_min, ovnode_mask, ovnode_sign, ovnode_idx});
        val_rel_q.push_back(cyc - start_cyc + 1);
      end
      if (omin_rden) begin
        rd_rel_q.push_back(cyc - start_cyc + 1);
        rd_addr_q.push_back(int'(omin_raddr));
      end
      if (odone) begin
        done_cnt = done_cnt + 1;
        done_rel = cyc - start_cyc + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic fill_mem();
    for (int r = 0; r < 16; r++) begin
      mem_min[r]  = vn_min_t'($urandom);
      mem_sign[r] = NDEG'($urandom);
    end
  endtask

  task automatic start_pass(input int num, input int deg);
    @(posedge iclk); #1;
    obs_q.delete(); rd_rel_q.delete(); rd_addr_q.delete(); val_rel_q.delete();
    done_cnt = 0; done_rel = -1;
    irow_num = 10'(num); irow_deg = vn_deg_t'(deg); istart = 1'b1; iclkena = 1'b1;
    @(posedge iclk); #1;
    start_cyc = cyc;
    istart = 1'b0;
    chk("busy_after_start", {63'd0, obusy}, 64'd1);
  endtask

  task automatic wait_done(input int budget, input bit rand_en);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge iclk); #1;
      iclkena = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    iclkena = 1'b1;
    chk("done_seen", {63'd0, done_cnt != 0}, 64'd1);
    @(posedge iclk); #1;
    @(posedge iclk); #1;
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("idle_not_busy", {63'd0, obusy}, 64'd0);
  endtask

  // reference: every row replays its word over all slots, slots past min(deg,8) masked
  task automatic compare_model(input int num, input int deg);
    logic [31:0] exp_q[$];
    int lim;
    lim = (deg > NDEG) ? NDEG : deg;
    for (int r = 0; r < num; r++)
      for (int s = 0; s < NDEG; s++)
        exp_q.push_back({1'b0, 10'(r), mem_min[r], (s >= lim), mem_sign[r][s], 3'(s)});
    chk("oval_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk("slot_tuple", 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  task automatic check_rows(input int num);
    chk("rden_count", 64'(rd_rel_q.size()), 64'(num));
    for (int i = 0; i < num; i++) begin
      chk("rden_cycle", 64'(qget(rd_rel_q, i)), 64'(1 + i * (NDEG + 3)));
      chk("rden_addr", 64'(qget(rd_addr_q, i)), 64'(i));
    end
  endtask

  initial begin
    int num, deg;
    ireset = 1'b1; iclkena = 1'b0; istart = 1'b0; irow_num = '0; irow_deg = '0;
    fill_mem();
    repeat (3) @(posedge iclk);
    #1; ireset = 1'b0; iclkena = 1'b1;
    chk("rst_oval", {63'd0, oval}, 64'd0);
    chk("rst_rden", {63'd0, omin_rden}, 64'd0);
    chk("rst_raddr", 64'(omin_raddr), 64'd0);
    chk("rst_busy", {63'd0, obusy}, 64'd0);
    chk("rst_done", {63'd0, odone}, 64'd0);

    // single full-degree row with exact timing
    fill_mem();
    start_pass(1, 8);
    wait_done(60, 1'b0);
    check_rows(1);
    chk("first_oval", 64'(qget(val_rel_q, 0)), 64'd4);
    chk("last_oval", 64'(qget(val_rel_q, val_rel_q.size() - 1)), 64'd11);
    chk("done_cycle", 64'(done_rel), 64'd12);
    compare_model(1, 8);

    // three rows, degree 5
    fill_mem();
    start_pass(3, 5);
    wait_done(100, 1'b0);
    check_rows(3);
    compare_model(3, 5);

    // empty pass
    start_pass(0, 4);
    wait_done(20, 1'b0);
    chk("empty_rden", 64'(rd_rel_q.size()), 64'd0);
    chk("empty_oval", 64'(obs_q.size()), 64'd0);
    chk("empty_done_cycle", 64'(done_rel), 64'd1);

    // random passes including degree 0 and clamped degrees
    for (int k = 0; k < 5; k++) begin
      num = $urandom_range(1, 4);
      deg = (k == 0) ? 0 : (k == 1) ? 15 : $urandom_range(0, 15);
      fill_mem();
      start_pass(num, deg);
      wait_done(num * 11 + 30, 1'b0);
      check_rows(num);
      compare_model(num, deg);
    end

    // random clock enable over a two-row pass
    fill_mem();
    deg = $urandom_range(1, 9);
    start_pass(2, deg);
    wait_done(400, 1'b1);
    compare_model(2, deg);

    // istart mid-pass is ignored
    fill_mem();
    start_pass(2, 6);
    repeat (5) @(posedge iclk);
    #1; istart = 1'b1; irow_num = 10'd7; irow_deg = 4'd2;
    @(posedge iclk); #1; istart = 1'b0;
    wait_done(80, 1'b0);
    check_rows(2);
    compare_model(2, 6);

    // reset at row 1 slot 3 aborts the pass
    fill_mem();
    start_pass(3, 8);
    num = 0;
    while (!(oval && octx == 10'd1 && ovnode_idx == 3'd3) && num < 60) begin
      @(posedge iclk); #1; num++;
    end
    chk("reach_row1_slot3", {63'd0, num < 60}, 64'd1);
    ireset = 1'b1;
    @(posedge iclk); #1; ireset = 1'b0;
    chk("abort_oval", {63'd0, oval}, 64'd0);
    chk("abort_busy", {63'd0, obusy}, 64'd0);
    chk("abort_rden", {63'd0, omin_rden}, 64'd0);
    repeat (15) @(posedge iclk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_idle_oval", {63'd0, oval}, 64'd0);

    fill_mem();
    start_pass(2, 3);
    wait_done(60, 1'b0);
    check_rows(2);
    compare_model(2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
